// File: rtl/core_v_xif_pkg.sv
// CORE-V-XIF transaction types used by the offload path.
// Widths follow a 32-bit core with two source registers.
package core_v_xif_pkg;

   localparam int unsigned X_ID_WIDTH  = 4;
   localparam int unsigned X_NUM_RS    = 2;
   localparam int unsigned X_RFR_WIDTH = 32;

   typedef struct packed {
      logic [31:0]                            instr;
      logic [1:0]                             mode;
      logic [X_ID_WIDTH-1:0]                  id;
      logic [X_NUM_RS-1:0][X_RFR_WIDTH-1:0]   rs;
      logic [X_NUM_RS-1:0]                    rs_valid;
   } x_issue_req_t;

   typedef struct packed {
      logic accept;
      logic writeback;
      logic dualwrite;
      logic dualread;
      logic loadstore;
      logic ecswrite;
      logic exc;
   } x_issue_resp_t;

   typedef struct packed {
      logic [X_ID_WIDTH-1:0] id;
      logic                  commit_kill;
   } x_commit_t;

endpackage

// File: rtl/lzc.sv
// Leading/trailing zero counter, interface-compatible with common_cells lzc.
// MODE=0 counts trailing zeros (index of lowest set bit), MODE=1 leading zeros.
module lzc #(
   parameter int unsigned WIDTH     = 4,
   parameter bit          MODE      = 1'b0,
   parameter int unsigned CNT_WIDTH = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
   input  logic [WIDTH-1:0]     in_i,
   output logic [CNT_WIDTH-1:0] cnt_o,
   output logic                 empty_o
);

   always_comb begin
      cnt_o   = '0;
      empty_o = 1'b1;
      // Scan so that the winning bit is the last one written.
      for (int k = 0; k < WIDTH; k++) begin
         if (MODE) begin
            if (in_i[k]) begin
               cnt_o   = CNT_WIDTH'(WIDTH - 1 - k);
               empty_o = 1'b0;
            end
         end else begin
            if (in_i[WIDTH-1-k]) begin
               cnt_o   = CNT_WIDTH'(WIDTH - 1 - k);
               empty_o = 1'b0;
            end
         end
      end
   end

endmodule

// File: rtl/xif_commit_queue.sv
// Speculation buffer: holds offloaded instructions until commit/kill, then
// forwards committed ones downstream in issue order and drops killed ones.
module xif_commit_queue
   import core_v_xif_pkg::*;
#(
   parameter int unsigned Depth   = 4,
   parameter int unsigned IdWidth = X_ID_WIDTH
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          x_issue_valid_i,
   output logic          x_issue_ready_o,
   input  x_issue_req_t  x_issue_req_i,
   output x_issue_resp_t x_issue_resp_o,
   input  x_issue_resp_t predec_resp_i,
   input  logic          x_commit_valid_i,
   input  x_commit_t     x_commit_i,
   output logic          insn_valid_o,
   input  logic          insn_ready_i,
   output x_issue_req_t  insn_o,
   output logic          empty_o,
   output logic [$clog2(Depth+1)-1:0] usage_o
);

   localparam int unsigned PtrW = $clog2(Depth);
   localparam int unsigned CntW = $clog2(Depth + 1);

   if (Depth < 2 || (Depth & (Depth - 1)) != 0) begin : g_depth_chk
      $error("xif_commit_queue: Depth must be a power of two >= 2");
   end

   typedef struct packed {
      logic         valid;
      logic         committed;
      logic         killed;
      x_issue_req_t req;
   } entry_t;

   entry_t          entry_q [Depth];
   entry_t          entry_d [Depth];
   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0] count_q, count_d;

   logic               push, pop;
   logic [Depth-1:0]   match, match_rot;
   logic [PtrW-1:0]    hit_off, hit_idx;
   logic               no_hit;
   logic [IdWidth-1:0] commit_id;
   entry_t             head;

   assign x_issue_ready_o = (count_q != CntW'(Depth));
   assign x_issue_resp_o  = predec_resp_i;
   assign push = x_issue_valid_i & x_issue_ready_o & predec_resp_i.accept;

   assign head         = entry_q[rd_ptr_q];
   assign insn_valid_o = head.valid & head.committed & ~head.killed;
   assign insn_o       = head.req;
   assign pop          = head.valid & head.committed & (head.killed | insn_ready_i);

   assign commit_id = IdWidth'(x_commit_i.id);

   // The slot at wr_ptr is free whenever a push happens, so the incoming
   // request stands in for it and is naturally the youngest candidate.
   always_comb begin
      match = '0;
      for (int i = 0; i < Depth; i++) begin
         match[i] = entry_q[i].valid & ~entry_q[i].committed &
                    (IdWidth'(entry_q[i].req.id) == commit_id);
         if (push && wr_ptr_q == PtrW'(i)) begin
            match[i] = (IdWidth'(x_issue_req_i.id) == commit_id);
         end
      end
   end

   // Rotate so bit 0 is the head; the lowest set bit is then the oldest match.
   always_comb begin
      match_rot = '0;
      for (int j = 0; j < Depth; j++) begin
         match_rot[j] = match[rd_ptr_q + PtrW'(j)];
      end
   end

   lzc #(
      .WIDTH (Depth),
      .MODE  (1'b0)
   ) i_lzc (
      .in_i    (match_rot),
      .cnt_o   (hit_off),
      .empty_o (no_hit)
   );

   assign hit_idx = rd_ptr_q + hit_off;

   always_comb begin
      for (int i = 0; i < Depth; i++) begin
         entry_d[i] = entry_q[i];
      end
      if (push) begin
         entry_d[wr_ptr_q].valid     = 1'b1;
         entry_d[wr_ptr_q].committed = 1'b0;
         entry_d[wr_ptr_q].killed    = 1'b0;
         entry_d[wr_ptr_q].req       = x_issue_req_i;
      end
      if (x_commit_valid_i && !no_hit) begin
         entry_d[hit_idx].committed = 1'b1;
         entry_d[hit_idx].killed    = x_commit_i.commit_kill;
      end
      if (pop) begin
         entry_d[rd_ptr_q].valid = 1'b0;
      end
   end

   assign wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
   assign rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
   assign count_d  = count_q + CntW'(push) - CntW'(pop);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < Depth; i++) begin
            entry_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         for (int i = 0; i < Depth; i++) begin
            entry_q[i] <= entry_d[i];
         end
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign empty_o = (count_q == '0);
   assign usage_o = count_q;

endmodule

// File: tb/tb_xif_commit_queue.sv
// Bench for xif_commit_queue: directed scenarios followed by random traffic,
// all compared against an in-order queue model of pending instructions.
module tb_xif_commit_queue;
   import core_v_xif_pkg::*;

   localparam int unsigned DEPTH = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          iv = 1'b0;
   logic          issue_ready;
   x_issue_req_t  ireq = '0;
   x_issue_resp_t resp_o;
   x_issue_resp_t presp = '0;
   logic          cv = 1'b0;
   x_commit_t     cmt = '0;
   logic          insn_valid;
   logic          rdy = 1'b0;
   x_issue_req_t  insn;
   logic          empty;
   logic [$clog2(DEPTH+1)-1:0] usage;

   int errors = 0;
   int checks = 0;

   typedef struct {
      x_issue_req_t req;
      bit           committed;
      bit           killed;
   } m_t;
   m_t mq[$];

   x_issue_req_t saved;

   xif_commit_queue #(.Depth(DEPTH), .IdWidth(X_ID_WIDTH)) dut (
      .clk_i            (clk),
      .rst_ni           (rst_n),
      .x_issue_valid_i  (iv),
      .x_issue_ready_o  (issue_ready),
      .x_issue_req_i    (ireq),
      .x_issue_resp_o   (resp_o),
      .predec_resp_i    (presp),
      .x_commit_valid_i (cv),
      .x_commit_i       (cmt),
      .insn_valid_o     (insn_valid),
      .insn_ready_i     (rdy),
      .insn_o           (insn),
      .empty_o          (empty),
      .usage_o          (usage)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input bit v, input int id, input bit acc,
                        input bit c, input int cid, input bit k, input bit r);
      iv                = v;
      ireq.instr        = $urandom;
      ireq.mode         = 2'($urandom);
      ireq.id           = X_ID_WIDTH'(id);
      ireq.rs[0]        = $urandom;
      ireq.rs[1]        = $urandom;
      ireq.rs_valid     = 2'($urandom);
      presp             = x_issue_resp_t'($urandom);
      presp.accept      = acc;
      cv                = c;
      cmt.id            = X_ID_WIDTH'(cid);
      cmt.commit_kill   = k;
      rdy               = r;
   endtask

   task automatic check_outputs();
      bit exp_v;
      exp_v = (mq.size() > 0) && mq[0].committed && !mq[0].killed;
      chk("issue_ready", issue_ready, mq.size() != DEPTH);
      chk("empty", empty, mq.size() == 0);
      chk("usage", usage, mq.size());
      chk("insn_valid", insn_valid, exp_v);
      chk("issue_resp", resp_o, presp);
      if (exp_v) chk("insn_o", insn, mq[0].req);
   endtask

   // Pending instructions in issue order; commits mark the oldest uncommitted
   // same-id instruction, and a committed head leaves on kill or on acceptance.
   task automatic model_update();
      bit push, pop;
      push = iv && (mq.size() != DEPTH) && presp.accept;
      pop  = (mq.size() > 0) && mq[0].committed && (mq[0].killed || rdy);
      if (push) mq.push_back('{req: ireq, committed: 1'b0, killed: 1'b0});
      if (cv) begin
         for (int k = 0; k < mq.size(); k++) begin
            if (!mq[k].committed && mq[k].req.id == cmt.id) begin
               mq[k].committed = 1'b1;
               mq[k].killed    = cmt.commit_kill;
               break;
            end
         end
      end
      if (pop) void'(mq.pop_front());
   endtask

   task automatic cycle();
      #1;
      check_outputs();
      @(posedge clk);
      model_update();
      @(negedge clk);
   endtask

   task automatic idle(input bit r, input int n);
      for (int i = 0; i < n; i++) begin
         drive(0, 0, 0, 0, 0, 0, r);
         cycle();
      end
   endtask

   initial begin
      drive(0, 0, 0, 0, 0, 0, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      chk("rst_ready", issue_ready, 1'b1);
      chk("rst_empty", empty, 1'b1);
      chk("rst_usage", usage, 0);
      chk("rst_insn_valid", insn_valid, 1'b0);

      // Issue and commit id 3 in the same cycle.
      drive(1, 3, 1, 1, 3, 0, 0);
      cycle();
      chk("same_cyc_valid", insn_valid, 1'b1);
      chk("same_cyc_id", insn.id, 3);
      chk("same_cyc_usage", usage, 1);
      idle(1, 1);
      chk("same_cyc_drained", usage, 0);

      // Out-of-order commit with a kill in the middle.
      drive(1, 0, 1, 0, 0, 0, 1); cycle();
      drive(1, 1, 1, 0, 0, 0, 1); cycle();
      drive(1, 2, 1, 0, 0, 0, 1); cycle();
      drive(0, 0, 0, 1, 2, 0, 1); cycle();
      drive(0, 0, 0, 1, 0, 1, 1); cycle();
      chk("kill_head_hidden", insn_valid, 1'b0);
      drive(0, 0, 0, 1, 1, 0, 1); cycle();
      chk("ooo_first_id", insn.id, 1);
      idle(1, 1);
      chk("ooo_second_id", insn.id, 2);
      idle(1, 2);

      // Fill to Depth, then free one slot.
      for (int i = 0; i < DEPTH; i++) begin
         drive(1, 8 + i, 1, 0, 0, 0, 0);
         cycle();
      end
      chk("full_ready", issue_ready, 1'b0);
      drive(1, 12, 1, 1, 8, 0, 1); cycle();
      chk("full_still", issue_ready, 1'b0);
      drive(0, 0, 0, 0, 0, 0, 1); cycle();
      chk("full_released", issue_ready, 1'b1);
      for (int i = 1; i < DEPTH; i++) begin
         drive(0, 0, 0, 1, 8 + i, 0, 1);
         cycle();
      end
      idle(1, 2);

      // Rejected issue stores nothing; a later commit of that id is ignored.
      drive(1, 5, 0, 0, 0, 0, 1); #1;
      chk("reject_resp", resp_o.accept, 1'b0);
      cycle();
      chk("reject_usage", usage, 0);
      drive(0, 0, 0, 1, 5, 0, 1); cycle();
      chk("reject_commit_ignored", insn_valid, 1'b0);

      // Backpressure on a committed head.
      drive(1, 6, 1, 1, 6, 0, 0); saved = ireq; cycle();
      drive(1, 7, 1, 1, 7, 0, 0); cycle();
      for (int i = 0; i < 3; i++) begin
         chk("stall_valid", insn_valid, 1'b1);
         chk("stall_stable", insn, saved);
         idle(0, 1);
      end
      idle(1, 3);

      // Reset with committed entries pending.
      drive(1, 1, 1, 1, 1, 0, 0); cycle();
      drive(1, 2, 1, 1, 2, 0, 0); cycle();
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", insn_valid, 1'b0);
      chk("mid_rst_empty", empty, 1'b1);
      chk("mid_rst_ready", issue_ready, 1'b1);
      mq.delete();
      @(negedge clk);
      rst_n = 1'b1;
      drive(0, 0, 0, 1, 1, 0, 1); cycle();
      drive(0, 0, 0, 1, 2, 0, 1); cycle();
      chk("post_rst_usage", usage, 0);

      // Random traffic.
      for (int n = 0; n < 600; n++) begin
         drive($urandom_range(1, 0), $urandom_range(7, 0), ($urandom_range(3, 0) != 0),
               $urandom_range(1, 0), $urandom_range(7, 0), ($urandom_range(2, 0) == 0),
               ($urandom_range(2, 0) != 0));
         cycle();
      end
      idle(1, 4);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
